// File: rtl/memisq_param_if.sv
// Bundle of dispatch, wakeup, flush and issue signals for the memory issue queue.
// master = dispatch/LSU side that drives requests; slave = the queue itself.
interface memisq_param_if #(
  parameter int DISP_W = 2,
  parameter int NUM_WB = 4,
  parameter int PRF_W  = 6,
  parameter int ROB_W  = 5,
  parameter int CTRL_W = 32
);
  localparam int FC_W = $clog2(DISP_W + 1);

  logic [DISP_W-1:0]           enq_valid;
  logic [DISP_W*PRF_W-1:0]     enq_src1_id;
  logic [DISP_W*PRF_W-1:0]     enq_src2_id;
  logic [DISP_W-1:0]           enq_rs1_used;
  logic [DISP_W-1:0]           enq_rs2_used;
  logic [DISP_W-1:0]           enq_src1_busy;
  logic [DISP_W-1:0]           enq_src2_busy;
  logic [DISP_W*PRF_W-1:0]     enq_T;
  logic [DISP_W*32-1:0]        enq_pc;
  logic [DISP_W*(ROB_W+1)-1:0] enq_robid;
  logic [DISP_W*CTRL_W-1:0]    enq_ctrl;
  logic [FC_W-1:0]             free_cnt;

  logic [NUM_WB-1:0]           wb_valid;
  logic [NUM_WB-1:0]           wb_need_wb;
  logic [NUM_WB*PRF_W-1:0]     wb_prd;

  logic                        flush_valid;
  logic [ROB_W:0]              flush_robid;

  logic                        iss_stall;
  logic                        iss_valid;
  logic [PRF_W-1:0]            iss_src1_id;
  logic [PRF_W-1:0]            iss_src2_id;
  logic [PRF_W-1:0]            iss_T;
  logic [31:0]                 iss_pc;
  logic [ROB_W:0]              iss_robid;
  logic [CTRL_W-1:0]           iss_ctrl;

  modport master (
    output enq_valid, enq_src1_id, enq_src2_id, enq_rs1_used, enq_rs2_used,
           enq_src1_busy, enq_src2_busy, enq_T, enq_pc, enq_robid, enq_ctrl,
           wb_valid, wb_need_wb, wb_prd, flush_valid, flush_robid, iss_stall,
    input  free_cnt, iss_valid, iss_src1_id, iss_src2_id, iss_T, iss_pc,
           iss_robid, iss_ctrl
  );

  modport slave (
    input  enq_valid, enq_src1_id, enq_src2_id, enq_rs1_used, enq_rs2_used,
           enq_src1_busy, enq_src2_busy, enq_T, enq_pc, enq_robid, enq_ctrl,
           wb_valid, wb_need_wb, wb_prd, flush_valid, flush_robid, iss_stall,
    output free_cnt, iss_valid, iss_src1_id, iss_src2_id, iss_T, iss_pc,
           iss_robid, iss_ctrl
  );
endinterface

// File: rtl/memisq_param.sv
// In-order memory issue queue: circular buffer, oldest-only issue, writeback wakeup, ROB-id flush.
// Define MEMISQ_WB_BYPASS_EN to let the tail issue in the same cycle as its wakeup.
module memisq_param #(
  parameter int DEPTH  = 8,
  parameter int DISP_W = 2,
  parameter int NUM_WB = 4,
  parameter int PRF_W  = 6,
  parameter int ROB_W  = 5,
  parameter int CTRL_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  memisq_param_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int RID_W = ROB_W + 1;
  localparam int FC_W  = $clog2(DISP_W + 1);

  typedef struct packed {
    logic [PRF_W-1:0]  src1;
    logic [PRF_W-1:0]  src2;
    logic              used1;
    logic              used2;
    logic              busy1;
    logic              busy2;
    logic [PRF_W-1:0]  T;
    logic [31:0]       pc;
    logic [RID_W-1:0]  robid;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t           r_ent [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [NUM_WB-1:0] w_wb_en;
  logic [CNT_W-1:0]  w_free;
  logic [FC_W-1:0]   w_free_cnt;
  logic [CNT_W-1:0]  w_n_req;
  logic [CNT_W-1:0]  w_n_acc;
  logic [DISP_W-1:0] w_lane_acc;
  logic [IDX_W-1:0]  w_slot [DISP_W];
  entry_t            w_new  [DISP_W];
  entry_t            w_tail;
  logic              w_busy1_eff;
  logic              w_busy2_eff;
  logic              w_ready;
  logic              w_iss;
  logic [DEPTH-1:0]  w_kill;
  logic [CNT_W-1:0]  w_surv;
  logic [IDX_W-1:0]  w_fidx;

  function automatic logic wb_hit(input logic [PRF_W-1:0] id,
                                  input logic [NUM_WB-1:0] en,
                                  input logic [NUM_WB*PRF_W-1:0] prd);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++)
      if (en[k] && (prd[k*PRF_W +: PRF_W] == id)) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic is_younger(input logic [RID_W-1:0] e, input logic [RID_W-1:0] f);
    if (e[ROB_W] == f[ROB_W]) return e[ROB_W-1:0] > f[ROB_W-1:0];
    else                      return e[ROB_W-1:0] < f[ROB_W-1:0];
  endfunction

  assign w_wb_en    = bus.wb_valid & bus.wb_need_wb;
  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign w_free_cnt = (w_free >= CNT_W'(DISP_W)) ? FC_W'(DISP_W) : FC_W'(w_free);
  assign bus.free_cnt = w_free_cnt;

  // Valid lanes are packed contiguously from head; lanes beyond free_cnt are dropped.
  always_comb begin
    w_n_req    = '0;
    w_n_acc    = '0;
    w_lane_acc = '0;
    for (int k = 0; k < DISP_W; k++) begin
      w_slot[k]       = r_head + IDX_W'(w_n_req);
      w_new[k].src1   = bus.enq_src1_id[k*PRF_W +: PRF_W];
      w_new[k].src2   = bus.enq_src2_id[k*PRF_W +: PRF_W];
      w_new[k].used1  = bus.enq_rs1_used[k];
      w_new[k].used2  = bus.enq_rs2_used[k];
      w_new[k].busy1  = bus.enq_src1_busy[k] &
                        ~wb_hit(bus.enq_src1_id[k*PRF_W +: PRF_W], w_wb_en, bus.wb_prd);
      w_new[k].busy2  = bus.enq_src2_busy[k] &
                        ~wb_hit(bus.enq_src2_id[k*PRF_W +: PRF_W], w_wb_en, bus.wb_prd);
      w_new[k].T      = bus.enq_T[k*PRF_W +: PRF_W];
      w_new[k].pc     = bus.enq_pc[k*32 +: 32];
      w_new[k].robid  = bus.enq_robid[k*RID_W +: RID_W];
      w_new[k].ctrl   = bus.enq_ctrl[k*CTRL_W +: CTRL_W];
      if (bus.enq_valid[k]) begin
        if ((w_n_req < CNT_W'(w_free_cnt)) && !bus.flush_valid) begin
          w_lane_acc[k] = 1'b1;
          w_n_acc       = w_n_acc + 1'b1;
        end
        w_n_req = w_n_req + 1'b1;
      end
    end
  end

  assign w_tail = r_ent[r_tail];

  always_comb begin
    w_busy1_eff = w_tail.busy1;
    w_busy2_eff = w_tail.busy2;
`ifdef MEMISQ_WB_BYPASS_EN
    w_busy1_eff = w_tail.busy1 & ~wb_hit(w_tail.src1, w_wb_en, bus.wb_prd);
    w_busy2_eff = w_tail.busy2 & ~wb_hit(w_tail.src2, w_wb_en, bus.wb_prd);
`endif
    w_ready = (~w_tail.used1 | ~w_busy1_eff) & (~w_tail.used2 | ~w_busy2_eff);
  end

  assign w_iss = (r_count != '0) & r_vld[r_tail] & w_ready & ~bus.flush_valid & ~bus.iss_stall;

  assign bus.iss_valid   = w_iss;
  assign bus.iss_src1_id = w_tail.src1;
  assign bus.iss_src2_id = w_tail.src2;
  assign bus.iss_T       = w_tail.T;
  assign bus.iss_pc      = w_tail.pc;
  assign bus.iss_robid   = w_tail.robid;
  assign bus.iss_ctrl    = w_tail.ctrl;

  // Walk live entries oldest-first; age order makes the killed set a suffix.
  always_comb begin
    w_surv = '0;
    w_kill = '0;
    w_fidx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fidx = r_tail + IDX_W'(i);
      if (CNT_W'(i) < r_count) begin
        if (is_younger(r_ent[w_fidx].robid, bus.flush_robid)) w_kill[w_fidx] = 1'b1;
        else                                                  w_surv = w_surv + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_hit(r_ent[e].src1, w_wb_en, bus.wb_prd)) r_ent[e].busy1 <= 1'b0;
        if (wb_hit(r_ent[e].src2, w_wb_en, bus.wb_prd)) r_ent[e].busy2 <= 1'b0;
      end
      if (bus.flush_valid) begin
        r_vld   <= r_vld & ~w_kill;
        r_count <= w_surv;
        r_head  <= r_tail + IDX_W'(w_surv);
      end else begin
        for (int k = 0; k < DISP_W; k++) begin
          if (w_lane_acc[k]) begin
            r_ent[w_slot[k]] <= w_new[k];
            r_vld[w_slot[k]] <= 1'b1;
          end
        end
        if (w_iss) begin
          r_vld[r_tail] <= 1'b0;
          r_tail        <= r_tail + 1'b1;
        end
        r_head  <= r_head + IDX_W'(w_n_acc);
        r_count <= r_count + w_n_acc - CNT_W'(w_iss);
      end
    end
  end

  a_no_overdispatch : assert property (@(posedge clk) disable iff (!reset_n)
    (w_n_req <= CNT_W'(w_free_cnt)));

endmodule

// File: tb/tb_memisq_param.sv
// Bench for memisq_param: directed scenarios plus randomized traffic against a queue-based model.
module tb_memisq_param;
  localparam int DEPTH  = 8;
  localparam int DISP_W = 2;
  localparam int NUM_WB = 4;
  localparam int PRF_W  = 6;
  localparam int ROB_W  = 5;
  localparam int CTRL_W = 32;
  localparam int RID_W  = ROB_W + 1;
  localparam int FC_W   = $clog2(DISP_W + 1);
`ifdef MEMISQ_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [PRF_W-1:0]  s1;
    logic [PRF_W-1:0]  s2;
    logic              u1;
    logic              u2;
    logic              b1;
    logic              b2;
    logic [PRF_W-1:0]  t;
    logic [31:0]       pc;
    logic [RID_W-1:0]  robid;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t exp_q[$];

  memisq_param_if #(.DISP_W(DISP_W), .NUM_WB(NUM_WB), .PRF_W(PRF_W),
                    .ROB_W(ROB_W), .CTRL_W(CTRL_W)) bus ();

  memisq_param #(.DEPTH(DEPTH), .DISP_W(DISP_W), .NUM_WB(NUM_WB), .PRF_W(PRF_W),
                 .ROB_W(ROB_W), .CTRL_W(CTRL_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_wbhit(input logic [PRF_W-1:0] id);
    for (int k = 0; k < NUM_WB; k++)
      if (bus.wb_valid[k] && bus.wb_need_wb[k] && bus.wb_prd[k*PRF_W +: PRF_W] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t m_wake(input ent_t e);
    ent_t r;
    r = e;
    if (m_wbhit(e.s1)) r.b1 = 1'b0;
    if (m_wbhit(e.s2)) r.b2 = 1'b0;
    return r;
  endfunction

  function automatic bit m_src_ok(input logic u, input logic b, input logic [PRF_W-1:0] id);
    return !u || !b || (BYP && m_wbhit(id));
  endfunction

  function automatic bit m_iss();
    if (exp_q.size() == 0 || bus.flush_valid || bus.iss_stall) return 1'b0;
    return m_src_ok(exp_q[0].u1, exp_q[0].b1, exp_q[0].s1) &&
           m_src_ok(exp_q[0].u2, exp_q[0].b2, exp_q[0].s2);
  endfunction

  function automatic int m_free();
    int f;
    f = DEPTH - exp_q.size();
    return (f < DISP_W) ? f : DISP_W;
  endfunction

  // Younger means strictly ahead of the flush id by less than half the ROB id space.
  function automatic bit m_younger(input logic [RID_W-1:0] e, input logic [RID_W-1:0] f);
    int d;
    d = (int'(e) - int'(f) + (1 << RID_W)) % (1 << RID_W);
    return (d > 0) && (d < (1 << ROB_W));
  endfunction

  function automatic ent_t lane_ent(input int k);
    ent_t e;
    e.s1    = bus.enq_src1_id[k*PRF_W +: PRF_W];
    e.s2    = bus.enq_src2_id[k*PRF_W +: PRF_W];
    e.u1    = bus.enq_rs1_used[k];
    e.u2    = bus.enq_rs2_used[k];
    e.b1    = bus.enq_src1_busy[k];
    e.b2    = bus.enq_src2_busy[k];
    e.t     = bus.enq_T[k*PRF_W +: PRF_W];
    e.pc    = bus.enq_pc[k*32 +: 32];
    e.robid = bus.enq_robid[k*RID_W +: RID_W];
    e.ctrl  = bus.enq_ctrl[k*CTRL_W +: CTRL_W];
    return e;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then move to the next negedge.
  task automatic tick();
    ent_t nq[$];
    bit   fire;
    int   nfree;
    int   acc;
    fire  = m_iss();
    nfree = m_free();
    acc   = 0;
    if (!reset_n) begin
      exp_q.delete();
    end else if (bus.flush_valid) begin
      foreach (exp_q[i])
        if (!m_younger(exp_q[i].robid, bus.flush_robid)) nq.push_back(m_wake(exp_q[i]));
      exp_q = nq;
    end else begin
      if (fire) void'(exp_q.pop_front());
      foreach (exp_q[i]) exp_q[i] = m_wake(exp_q[i]);
      for (int k = 0; k < DISP_W; k++) begin
        if (bus.enq_valid[k]) begin
          if (acc < nfree) exp_q.push_back(m_wake(lane_ent(k)));
          acc++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    bus.enq_valid     = '0;
    bus.enq_src1_id   = '0;
    bus.enq_src2_id   = '0;
    bus.enq_rs1_used  = '0;
    bus.enq_rs2_used  = '0;
    bus.enq_src1_busy = '0;
    bus.enq_src2_busy = '0;
    bus.enq_T         = '0;
    bus.enq_pc        = '0;
    bus.enq_robid     = '0;
    bus.enq_ctrl      = '0;
    bus.wb_valid      = '0;
    bus.wb_need_wb    = '0;
    bus.wb_prd        = '0;
    bus.flush_valid   = 1'b0;
    bus.flush_robid   = '0;
    bus.iss_stall     = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [PRF_W-1:0] s1, input logic [PRF_W-1:0] s2,
                          input logic u1, input logic u2, input logic b1, input logic b2,
                          input logic [RID_W-1:0] rid, input logic [31:0] pc);
    bus.enq_valid[k]                    = 1'b1;
    bus.enq_src1_id[k*PRF_W +: PRF_W]   = s1;
    bus.enq_src2_id[k*PRF_W +: PRF_W]   = s2;
    bus.enq_rs1_used[k]                 = u1;
    bus.enq_rs2_used[k]                 = u2;
    bus.enq_src1_busy[k]                = b1;
    bus.enq_src2_busy[k]                = b2;
    bus.enq_T[k*PRF_W +: PRF_W]         = PRF_W'($urandom_range(0, 63));
    bus.enq_pc[k*32 +: 32]              = pc;
    bus.enq_robid[k*RID_W +: RID_W]     = rid;
    bus.enq_ctrl[k*CTRL_W +: CTRL_W]    = $urandom;
  endtask

  task automatic set_wb(input int k, input logic need, input logic [PRF_W-1:0] prd);
    bus.wb_valid[k]                = 1'b1;
    bus.wb_need_wb[k]              = need;
    bus.wb_prd[k*PRF_W +: PRF_W]   = prd;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_iss_valid got %0b exp 0", bus.iss_valid);
    end
    n_cmp++;
    if (bus.free_cnt !== FC_W'(DISP_W)) begin
      n_err++; $display("FAIL reset_free_cnt got %0d exp %0d", bus.free_cnt, DISP_W);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_dual_enq();
    logic [RID_W-1:0] want [3];
    want[0] = 6'd3; want[1] = 6'd4; want[2] = 6'd0;
    do_reset();
    set_lane(0, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 32'h1000);
    set_lane(1, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0, 1'b0, 6'd4, 32'h1004);
    #1;
    n_cmp++;
    if (bus.free_cnt !== 2'd2) begin
      n_err++; $display("FAIL dual_free_before got %0d exp 2", bus.free_cnt);
    end
    tick();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.iss_valid !== m_iss() || bus.iss_valid !== (c < 2)) begin
        n_err++; $display("FAIL dual_iss_valid c%0d got %0b exp %0b", c, bus.iss_valid, (c < 2));
      end else if (c < 2) begin
        n_cmp++;
        if (bus.iss_robid !== want[c] || bus.iss_pc !== exp_q[0].pc || bus.iss_ctrl !== exp_q[0].ctrl) begin
          n_err++; $display("FAIL dual_fields c%0d got robid %0d pc %h exp robid %0d pc %h",
                            c, bus.iss_robid, bus.iss_pc, want[c], exp_q[0].pc);
        end
      end
      if (c == 0) begin
        n_cmp++;
        if (bus.free_cnt !== 2'd2) begin
          n_err++; $display("FAIL dual_free_after got %0d exp 2", bus.free_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_lane1_only();
    do_reset();
    set_lane(1, 6'd7, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9, 32'hCAFE_0010);
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b1 || bus.iss_pc !== 32'hCAFE_0010 || bus.iss_src1_id !== 6'd7
        || bus.iss_src2_id !== 6'd8 || bus.iss_T !== exp_q[0].t) begin
      n_err++; $display("FAIL lane1_issue got v %0b pc %h s1 %0d s2 %0d exp v 1 pc cafe0010 s1 7 s2 8",
                        bus.iss_valid, bus.iss_pc, bus.iss_src1_id, bus.iss_src2_id);
    end
    n_cmp++;
    if (bus.free_cnt !== 2'd2) begin
      n_err++; $display("FAIL lane1_free got %0d exp 2", bus.free_cnt);
    end
    tick();
  endtask

  task automatic test_fill_wakeup();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      set_lane(0, 6'd9, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, RID_W'(2*c), 32'h2000 + 32'(8*c));
      set_lane(1, 6'd9, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, RID_W'(2*c+1), 32'h2004 + 32'(8*c));
      #1;
      n_cmp++;
      if (bus.iss_valid !== 1'b0 || bus.free_cnt !== FC_W'(m_free())) begin
        n_err++; $display("FAIL fill_step c%0d got v %0b free %0d exp v 0 free %0d",
                          c, bus.iss_valid, bus.free_cnt, m_free());
      end
      tick();
    end
    clear_inputs();
    #1;
    n_cmp++;
    if (bus.free_cnt !== '0 || bus.iss_valid !== 1'b0) begin
      n_err++; $display("FAIL full_state got free %0d v %0b exp free 0 v 0", bus.free_cnt, bus.iss_valid);
    end
    set_wb(2, 1'b1, 6'd9);
    #1;
    n_cmp++;
    if (bus.iss_valid !== BYP || bus.iss_valid !== m_iss()) begin
      n_err++; $display("FAIL wakeup_same_cycle got %0b exp %0b", bus.iss_valid, BYP);
    end
    tick();
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if (bus.iss_valid !== m_iss()) begin
        n_err++; $display("FAIL drain_iss_valid c%0d got %0b exp %0b", c, bus.iss_valid, m_iss());
      end else if (m_iss()) begin
        n_cmp++;
        if (bus.iss_robid !== exp_q[0].robid || bus.iss_pc !== exp_q[0].pc) begin
          n_err++; $display("FAIL drain_fields c%0d got robid %0d exp %0d", c, bus.iss_robid, exp_q[0].robid);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [RID_W-1:0] want [3];
    want[0] = 6'd30; want[1] = 6'd31; want[2] = 6'd34;
    do_reset();
    bus.iss_stall = 1'b1;
    set_lane(0, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd30, 32'h3000);
    set_lane(1, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd31, 32'h3004);
    tick();
    set_lane(0, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd32, 32'h3008);
    set_lane(1, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd33, 32'h300C);
    tick();
    clear_inputs();
    bus.flush_valid = 1'b1;
    bus.flush_robid = 6'd31;
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_no_issue got %0b exp 0", bus.iss_valid);
    end
    tick();
    clear_inputs();
    set_lane(0, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd34, 32'h3010);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (bus.iss_valid !== m_iss() || bus.iss_valid !== (c < 3)) begin
        n_err++; $display("FAIL flush_after_valid c%0d got %0b exp %0b", c, bus.iss_valid, (c < 3));
      end else if (c < 3) begin
        n_cmp++;
        if (bus.iss_robid !== want[c]) begin
          n_err++; $display("FAIL flush_order c%0d got robid %0d exp %0d", c, bus.iss_robid, want[c]);
        end
      end
      tick();
      clear_inputs();
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.iss_stall = 1'b1;
    set_lane(0, 6'd3, 6'd4, 1'b1, 1'b1, 1'b0, 1'b0, 6'd10, 32'h4000);
    tick();
    clear_inputs();
    bus.iss_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (bus.iss_valid !== 1'b0 || bus.iss_robid !== 6'd10) begin
        n_err++; $display("FAIL stall_hold c%0d got v %0b robid %0d exp v 0 robid 10", c, bus.iss_valid, bus.iss_robid);
      end
      tick();
    end
    clear_inputs();
    set_lane(0, 6'd3, 6'd4, 1'b1, 1'b1, 1'b0, 1'b0, 6'd11, 32'h4004);
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b1 || bus.iss_robid !== 6'd10) begin
      n_err++; $display("FAIL stall_release got v %0b robid %0d exp v 1 robid 10", bus.iss_valid, bus.iss_robid);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b1 || bus.iss_robid !== 6'd11 || exp_q.size() != 1) begin
      n_err++; $display("FAIL stall_concurrent got v %0b robid %0d exp v 1 robid 11", bus.iss_valid, bus.iss_robid);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_empty got %0b exp 0", bus.iss_valid);
    end
  endtask

  task automatic test_enq_wakeup();
    do_reset();
    set_lane(0, 6'd2, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 6'd20, 32'h5000);
    set_wb(0, 1'b1, 6'd5);
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0) begin
      n_err++; $display("FAIL enqwake_empty got %0b exp 0", bus.iss_valid);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b1 || bus.iss_robid !== 6'd20) begin
      n_err++; $display("FAIL enqwake_issue got v %0b robid %0d exp v 1 robid 20", bus.iss_valid, bus.iss_robid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_lane(0, 6'd9, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 32'h6000);
    set_lane(1, 6'd9, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 32'h6004);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clear_inputs();
    set_wb(0, 1'b1, 6'd9);
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0 || bus.free_cnt !== 2'd2) begin
      n_err++; $display("FAIL reset_mid got v %0b free %0d exp v 0 free 2", bus.iss_valid, bus.free_cnt);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_lost got %0b exp 0", bus.iss_valid);
    end
  endtask

  task automatic test_random();
    logic [RID_W-1:0] rid;
    int nfree;
    int n;
    rid = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      bus.iss_stall = ($urandom_range(0, 5) == 0);
      for (int w = 0; w < NUM_WB; w++)
        if ($urandom_range(0, 2) == 0) set_wb(w, 1'($urandom_range(0, 3) != 0), PRF_W'($urandom_range(0, 7)));
      if (c > 4 && $urandom_range(0, 15) == 0) begin
        bus.flush_valid = 1'b1;
        bus.flush_robid = rid - RID_W'($urandom_range(1, 8));
      end else begin
        nfree = m_free();
        n = 0;
        for (int k = 0; k < DISP_W; k++) begin
          if ($urandom_range(0, 1) == 1 && n < nfree) begin
            set_lane(k, PRF_W'($urandom_range(0, 7)), PRF_W'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rid, $urandom);
            rid = rid + 1'b1;
            n++;
          end
        end
      end
      #1;
      n_cmp++;
      if (bus.iss_valid !== m_iss() || bus.free_cnt !== FC_W'(m_free())) begin
        n_err++; $display("FAIL rand_ctl c%0d got v %0b free %0d exp v %0b free %0d",
                          c, bus.iss_valid, bus.free_cnt, m_iss(), m_free());
      end else if (m_iss()) begin
        n_cmp++;
        if (bus.iss_robid !== exp_q[0].robid || bus.iss_pc !== exp_q[0].pc ||
            bus.iss_ctrl !== exp_q[0].ctrl || bus.iss_T !== exp_q[0].t ||
            bus.iss_src1_id !== exp_q[0].s1 || bus.iss_src2_id !== exp_q[0].s2) begin
          n_err++; $display("FAIL rand_fields c%0d got robid %0d pc %h exp robid %0d pc %h",
                            c, bus.iss_robid, bus.iss_pc, exp_q[0].robid, exp_q[0].pc);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_dual_enq();
    test_lane1_only();
    test_fill_wakeup();
    test_flush();
    test_stall();
    test_enq_wakeup();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
